// File: rtl/soc_protection_hyst.sv
// soc_protection_hyst: debounced, hysteretic state-of-charge fault detection.
// A low/high fault is entered after DEBOUNCE consecutive qualifying samples
// and left after DEBOUNCE consecutive samples past the limit plus HYST.
// Optional build macro SOC_FAULT_LATCH_EN: faults stay latched after recovery
// until acknowledged with clear_fault.
module soc_protection_hyst #(
    parameter int unsigned SOC_W      = 8,
    parameter int unsigned LOW_LIMIT  = 10,
    parameter int unsigned HIGH_LIMIT = 95,
    parameter int unsigned HYST       = 3,
    parameter int unsigned DEBOUNCE   = 4,
    localparam int unsigned CNT_W     = $clog2(DEBOUNCE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soc_valid,
    input  logic [SOC_W-1:0] soc_percent,
    input  logic             clear_fault,
    output logic             soc_low_fault,
    output logic             soc_high_fault,
    output logic             soc_ok,
    output logic             fault_evt,
    output logic [CNT_W-1:0] deb_cnt
);

    typedef enum logic [2:0] {
        S_NORMAL,
        S_LOW_PEND,
        S_LOW_FAULT,
        S_HIGH_PEND,
        S_HIGH_FAULT
    } state_t;

    // Thresholds are held one bit wider than the sample so LIMIT+HYST cannot wrap.
    localparam logic [SOC_W:0]   LOW_ENTER  = (SOC_W + 1)'(LOW_LIMIT);
    localparam logic [SOC_W:0]   LOW_EXIT   = (SOC_W + 1)'(LOW_LIMIT + HYST);
    localparam logic [SOC_W:0]   HIGH_ENTER = (SOC_W + 1)'(HIGH_LIMIT);
    localparam logic [SOC_W:0]   HIGH_EXIT  = (SOC_W + 1)'(HIGH_LIMIT - HYST);
    localparam logic [CNT_W-1:0] DEB_MAX    = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt_n, cnt_inc;
    logic [SOC_W:0]   soc_ext;
    logic             low_q, high_q, low_rec, high_rec, rec;
    logic             in_fault, in_fault_n;

    assign soc_ext  = {1'b0, soc_percent};
    assign low_q    = soc_ext <= LOW_ENTER;
    assign high_q   = soc_ext >= HIGH_ENTER;
    assign low_rec  = soc_ext >= LOW_EXIT;
    assign high_rec = soc_ext <= HIGH_EXIT;
    assign rec      = (state == S_LOW_FAULT) ? low_rec : high_rec;
    assign cnt_inc  = deb_cnt + CNT_ONE;
    assign in_fault   = (state == S_LOW_FAULT) || (state == S_HIGH_FAULT);
    assign in_fault_n = (state_n == S_LOW_FAULT) || (state_n == S_HIGH_FAULT);

`ifndef SOC_FAULT_LATCH_EN
    // The acknowledge input has no function when faults auto-clear.
    logic clear_fault_unused;
    assign clear_fault_unused = clear_fault;
`endif

    // Next-state and debounce counter decode.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_n = state;
        cnt_n   = deb_cnt;
        unique case (state)
            S_NORMAL: begin
                if (soc_valid) begin
                    if (low_q) begin
                        state_n = (DEBOUNCE == 1) ? S_LOW_FAULT : S_LOW_PEND;
                        cnt_n   = (DEBOUNCE == 1) ? '0 : CNT_ONE;
                    end else if (high_q) begin
                        state_n = (DEBOUNCE == 1) ? S_HIGH_FAULT : S_HIGH_PEND;
                        cnt_n   = (DEBOUNCE == 1) ? '0 : CNT_ONE;
                    end else begin
                        cnt_n = '0;
                    end
                end
            end
            S_LOW_PEND, S_HIGH_PEND: begin
                if (soc_valid) begin
                    if ((state == S_LOW_PEND) ? low_q : high_q) begin
                        if (cnt_inc == DEB_MAX) begin
                            state_n = (state == S_LOW_PEND) ? S_LOW_FAULT : S_HIGH_FAULT;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else if ((state == S_LOW_PEND) ? high_q : low_q) begin
                        // Crossing straight to the opposite pending state restarts the count.
                        state_n = (state == S_LOW_PEND) ? S_HIGH_PEND : S_LOW_PEND;
                        cnt_n   = CNT_ONE;
                    end else begin
                        state_n = S_NORMAL;
                        cnt_n   = '0;
                    end
                end
            end
            S_LOW_FAULT, S_HIGH_FAULT: begin
`ifdef SOC_FAULT_LATCH_EN
                if (soc_valid && !rec) begin
                    // A non-recovery sample also cancels a same-cycle acknowledge.
                    cnt_n = '0;
                end else begin
                    if (soc_valid && (deb_cnt != DEB_MAX))
                        cnt_n = cnt_inc;
                    if (clear_fault && (deb_cnt == DEB_MAX)) begin
                        state_n = S_NORMAL;
                        cnt_n   = '0;
                    end
                end
`else
                if (soc_valid) begin
                    if (!rec) begin
                        cnt_n = '0;
                    end else if (cnt_inc == DEB_MAX) begin
                        state_n = S_NORMAL;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
`endif
            end
            default: begin
                state_n = S_NORMAL;
                cnt_n   = '0;
            end
        endcase
    end

    // State, counter and registered output flags.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state          <= S_NORMAL;
            deb_cnt        <= '0;
            soc_low_fault  <= 1'b0;
            soc_high_fault <= 1'b0;
            soc_ok         <= 1'b1;
            fault_evt      <= 1'b0;
        end else begin
            state          <= state_n;
            deb_cnt        <= cnt_n;
            soc_low_fault  <= (state_n == S_LOW_FAULT);
            soc_high_fault <= (state_n == S_HIGH_FAULT);
            soc_ok         <= !in_fault_n;
            fault_evt      <= in_fault_n && !in_fault;
        end
    end

endmodule

// File: tb/tb_soc_protection_hyst.sv
// Directed self-checking bench for soc_protection_hyst (default parameters).
module tb_soc_protection_hyst;

    localparam int unsigned SOC_W      = 8;
    localparam int unsigned LOW_LIMIT  = 10;
    localparam int unsigned HIGH_LIMIT = 95;
    localparam int unsigned HYST       = 3;
    localparam int unsigned DEBOUNCE   = 4;
    localparam int unsigned CNT_W      = $clog2(DEBOUNCE + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             soc_valid;
    logic [SOC_W-1:0] soc_percent;
    logic             clear_fault;
    logic             soc_low_fault, soc_high_fault, soc_ok, fault_evt;
    logic [CNT_W-1:0] deb_cnt;

    int errors = 0;
    int checks = 0;

    soc_protection_hyst #(
        .SOC_W(SOC_W), .LOW_LIMIT(LOW_LIMIT), .HIGH_LIMIT(HIGH_LIMIT),
        .HYST(HYST), .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk(clk), .rst(rst), .soc_valid(soc_valid), .soc_percent(soc_percent),
        .clear_fault(clear_fault), .soc_low_fault(soc_low_fault),
        .soc_high_fault(soc_high_fault), .soc_ok(soc_ok), .fault_evt(fault_evt),
        .deb_cnt(deb_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic low, input logic high,
                             input logic ok, input logic evt, input int cnt);
        check({tag, ".low"},  32'(soc_low_fault),  32'(low));
        check({tag, ".high"}, 32'(soc_high_fault), 32'(high));
        check({tag, ".ok"},   32'(soc_ok),         32'(ok));
        check({tag, ".evt"},  32'(fault_evt),      32'(evt));
        check({tag, ".cnt"},  32'(deb_cnt),        32'(cnt));
    endtask

    // Called at a falling edge: present one sample for one cycle, then idle for gap cycles.
    task automatic sample(input int v, input int gap = 0);
        soc_valid   = 1'b1;
        soc_percent = SOC_W'(v);
        @(negedge clk);
        soc_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        if (!(LOW_LIMIT + HYST < HIGH_LIMIT - HYST) || (HIGH_LIMIT >= 2 ** SOC_W)) begin
            $display("FAIL legality: illegal parameter set");
            $fatal(1, "illegal parameters");
        end

        rst = 1'b1; soc_valid = 1'b0; soc_percent = '0; clear_fault = 1'b0;
        idle(2);
        rst = 1'b0;
        check_all("reset", 0, 0, 1, 0, 0);

        // Low entry: four samples at the limit.
        sample(10); sample(10); sample(10);
        check_all("low_pend3", 0, 0, 1, 0, 3);
        sample(10);
        check_all("low_entry", 1, 0, 0, 1, 0);
        idle(1);
        check_all("low_evt_end", 1, 0, 0, 0, 0);

`ifdef SOC_FAULT_LATCH_EN
        // Latched: recovery alone does not clear; acknowledge only after full recovery.
        sample(12); sample(12);
        check_all("latch_band", 1, 0, 0, 0, 0);
        sample(50); sample(50);
        pulse_clear();
        check_all("latch_early_clr", 1, 0, 0, 0, 2);
        sample(50); sample(50); sample(50);
        check_all("latch_sat", 1, 0, 0, 0, 4);
        pulse_clear();
        check_all("latch_clear", 0, 0, 1, 0, 0);
`else
        // Hysteresis band holds the fault; acknowledge is ignored.
        sample(12); sample(12); sample(12);
        check_all("band_hold", 1, 0, 0, 0, 0);
        pulse_clear();
        check_all("clr_ignored", 1, 0, 0, 0, 0);
        sample(13); sample(13); sample(13);
        check_all("rec3", 1, 0, 0, 0, 3);
        sample(12);
        check_all("rec_break", 1, 0, 0, 0, 0);
        sample(13); sample(13); sample(13); sample(13);
        check_all("low_exit", 0, 0, 1, 0, 0);
`endif

        // Debounce broken by a sample just above the limit.
        sample(10); sample(10); sample(10); sample(11);
        check_all("deb_break", 0, 0, 1, 0, 0);
        sample(94);
        check_all("below_high", 0, 0, 1, 0, 0);

        // Pending cross-over from low to high.
        sample(10); sample(10); sample(97);
        check_all("cross", 0, 0, 1, 0, 1);
        sample(50);
        check_all("cross_back", 0, 0, 1, 0, 0);

`ifndef SOC_FAULT_LATCH_EN
        // High path with idle gaps between samples.
        sample(95, 3);
        check_all("high_gap1", 0, 0, 1, 0, 1);
        sample(99, 3); sample(96, 3);
        check_all("high_gap3", 0, 0, 1, 0, 3);
        sample(255);
        check_all("high_entry", 0, 1, 0, 1, 0);
        idle(1);
        check_all("high_evt_end", 0, 1, 0, 0, 0);
        sample(92); sample(92); sample(93);
        check_all("high_rec_break", 0, 1, 0, 0, 0);
        sample(92); sample(92); sample(92);
        check_all("high_rec3", 0, 1, 0, 0, 3);
        sample(92);
        check_all("high_exit", 0, 0, 1, 0, 0);
`endif

        // Reset with a concurrent sample while in fault discards history.
        sample(10); sample(10); sample(10); sample(10);
        check_all("low_entry2", 1, 0, 0, 1, 0);
        sample(13); sample(13);
        rst = 1'b1; soc_valid = 1'b1; soc_percent = 8'd10; clear_fault = 1'b1;
        @(negedge clk);
        rst = 1'b0; soc_valid = 1'b0; clear_fault = 1'b0;
        check_all("rst_mid", 0, 0, 1, 0, 0);
        sample(10); sample(10); sample(10);
        check_all("post_rst", 0, 0, 1, 0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
